// File: rtl/tri_job_sched.sv
// Round-robin scheduler sharing one triangle rasterizer among NREQ requesters.
// Ports: clk/reset; req/req_tri/ack/done/pix_cnt requester side;
//   eng_nt/xi/yi load and eng_busy/po/xo/yo from the engine;
//   pix_valid/x/y/id registered pixel stream; err sticky watchdog flag.
module tri_job_sched #(
  parameter int NREQ       = 2,
  parameter int MAX_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*18-1:0] req_tri,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic [6:0]         pix_cnt,
  output logic               eng_nt,
  output logic [2:0]         eng_xi,
  output logic [2:0]         eng_yi,
  input  logic               eng_busy,
  input  logic               eng_po,
  input  logic [2:0]         eng_xo,
  input  logic [2:0]         eng_yo,
  output logic               pix_valid,
  output logic [2:0]         pix_x,
  output logic [2:0]         pix_y,
  output logic [1:0]         pix_id,
  output logic               err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND1 = 3'd1;
  localparam logic [2:0] S_SEND2 = 3'd2;
  localparam logic [2:0] S_SEND3 = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_FIN   = 3'd5;
  localparam logic [2:0] S_HALT  = 3'd6;

  localparam logic [7:0] WD_LAST = 8'(MAX_CYCLES - 1);

  logic [2:0]  state;
  logic [1:0]  ptr;
  logic [1:0]  id;
  logic [17:0] tri_q;
  logic [7:0]  wd;

  logic        gnt_ok;
  logic [1:0]  gnt_id;
  logic [1:0]  gnt_nxt;
  logic [17:0] gnt_tri;
  logic        hi_ok;
  logic [1:0]  hi_id;

  // Lowest set bit at or above ptr wins; otherwise wrap to lowest overall.
  // Descending scan so the lowest match is the last one written.
  always_comb begin
    gnt_ok = 1'b0;
    gnt_id = 2'd0;
    hi_ok  = 1'b0;
    hi_id  = 2'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_ok = 1'b1;
        gnt_id = 2'(i);
        if (2'(i) >= ptr) begin
          hi_ok = 1'b1;
          hi_id = 2'(i);
        end
      end
    end
    if (hi_ok) gnt_id = hi_id;
  end

  always_comb begin
    gnt_tri = 18'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == 2'(i)) gnt_tri = req_tri[18*i +: 18];
    end
  end

  assign gnt_nxt = (gnt_id == 2'(NREQ - 1)) ? 2'd0 : gnt_id + 2'd1;

  // ack is decoded in IDLE so the triangle is captured on that same edge;
  // gated by reset so it stays 0 while the FSM is held in IDLE by reset.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      ack[i]  = !reset && (state == S_IDLE) && gnt_ok
                && (gnt_id == 2'(i));
      done[i] = (state == S_FIN) && (id == 2'(i));
    end
  end

  always_comb begin
    eng_nt = 1'b0;
    eng_xi = 3'd0;
    eng_yi = 3'd0;
    case (state)
      S_SEND1: begin
        eng_nt = 1'b1;
        eng_xi = tri_q[2:0];
        eng_yi = tri_q[5:3];
      end
      S_SEND2: begin
        eng_xi = tri_q[8:6];
        eng_yi = tri_q[11:9];
      end
      S_SEND3: begin
        eng_xi = tri_q[14:12];
        eng_yi = tri_q[17:15];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      id        <= 2'd0;
      tri_q     <= 18'd0;
      wd        <= 8'd0;
      pix_cnt   <= 7'd0;
      err       <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= 3'd0;
      pix_y     <= 3'd0;
      pix_id    <= 2'd0;
    end else begin
      pix_valid <= eng_po;
      pix_x     <= eng_xo;
      pix_y     <= eng_yo;
      pix_id    <= id;
      case (state)
        S_IDLE: begin
          if (gnt_ok) begin
            tri_q <= gnt_tri;
            id    <= gnt_id;
            ptr   <= gnt_nxt;
            state <= S_SEND1;
          end
        end
        S_SEND1: begin
          pix_cnt <= 7'd0;
          state   <= S_SEND2;
        end
        S_SEND2: state <= S_SEND3;
        S_SEND3: begin
          wd    <= 8'd0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (eng_po && pix_cnt != 7'd127) pix_cnt <= pix_cnt + 7'd1;
          if (!eng_busy) begin
            state <= S_FIN;
          end else if (wd == WD_LAST) begin
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            wd <= wd + 8'd1;
          end
        end
        S_FIN:   state <= err ? S_HALT : S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
